msrv32_dmem_bus_ctrl: RTL and testbench

//  Sequences data-memory accesses from the MEM stage onto the AHB-lite data port.
//  - Accepts one aligned write (address, data, byte mask, from the store unit) and/or one read per request.
//  - Registers the address phase, then holds write data stable through wait states.
//  - Captures read data and stalls the pipeline until the transfer retires.
//  - Reports error responses and timeouts.

---
 rtl/msrv32_pkg.sv | 17 +
 rtl/msrv32_wait_timer.sv | 37 +++
 rtl/msrv32_dmem_bus_ctrl.sv | 161 ++++++++++++++++
 tb/tb_msrv32_dmem_bus_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings for the data-memory bus controller
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int WAIT_CNT_W       = 8;
  localparam int WAIT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/msrv32_wait_timer.sv
// rtl/msrv32_wait_timer.sv - data-phase wait counter with timeout flag
module msrv32_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST_WAIT);

  // Saturates at the timeout value so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msrv32_dmem_bus_ctrl.sv
// rtl/msrv32_dmem_bus_ctrl.sv - MEM-stage to AHB-lite data port sequencer
module msrv32_dmem_bus_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WAIT_TIMEOUT_DEF,
  parameter int CNT_W          = WAIT_CNT_W
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [3:0]  req_mask_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  input  logic [31:0] ahb_rdata_in,
  output logic [31:0] ahb_haddr_out,
  output logic [31:0] ahb_hwdata_out,
  output logic        ahb_hwrite_out,
  output logic [1:0]  ahb_htrans_out,
  output logic [3:0]  ahb_mask_out,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        bus_err_out
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_q, wr_d, rd_pend_q, rd_pend_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic        hwrite_q, hwrite_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [3:0]  hmask_q, hmask_d;
  logic        timer_expired;

  msrv32_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (ms_riscv32_mp_clk_in),
    .rst_n   (ms_riscv32_mp_rst_in),
    .clear   (state_q != ST_DATA),
    .enable  ((state_q == ST_DATA) && !ahb_ready_in),
    .expired (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    wr_d      = wr_q;
    rd_pend_d = rd_pend_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_wr_req_in || mem_rd_req_in) begin
          addr_d    = {req_addr_in[31:2], 2'b00};
          wdata_d   = req_wdata_in;
          mask_d    = req_mask_in;
          wr_d      = mem_wr_req_in;
          rd_pend_d = mem_wr_req_in && mem_rd_req_in;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ahb_ready_in) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ahb_resp_in) begin
          state_d = ST_ERR;
        end else if (ahb_ready_in) begin
          if (!wr_q) begin
            rdata_d  = ahb_rdata_in;
            rvalid_d = 1'b1;
          end
          // A write+read pair reissues the same address as a read.
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            wr_d      = 1'b0;
            state_d   = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_expired) begin
          state_d = ST_ERR;
        end
      end
      default: begin
        rd_pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Bus outputs are registered from the next state so they align with it.
    err_d    = (state_d == ST_ERR);
    htrans_d = HTRANS_IDLE;
    haddr_d  = '0;
    hwrite_d = 1'b0;
    hwdata_d = '0;
    hmask_d  = '0;
    if (state_d == ST_ADDR) begin
      htrans_d = HTRANS_NONSEQ;
      haddr_d  = addr_d;
      hwrite_d = wr_d;
    end else if (state_d == ST_DATA) begin
      hwdata_d = wdata_d;
      hmask_d  = wr_d ? mask_d : 4'b0000;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      wr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      hmask_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      wr_q      <= wr_d;
      rd_pend_q <= rd_pend_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      hmask_q   <= hmask_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign ahb_htrans_out  = htrans_q;
  assign ahb_haddr_out   = haddr_q;
  assign ahb_hwrite_out  = hwrite_q;
  assign ahb_hwdata_out  = hwdata_q;
  assign ahb_mask_out    = hmask_q;
  assign rdata_out       = rdata_q;
  assign rdata_valid_out = rvalid_q;
  assign bus_err_out     = err_q;
  assign stall_out       = (state_q != ST_IDLE) ||
                           ((mem_wr_req_in || mem_rd_req_in) && (state_q == ST_IDLE));

endmodule

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
// tb/tb_msrv32_dmem_bus_ctrl.sv - scoreboard bench for the data-memory bus controller
module tb_msrv32_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_wr_req_in, mem_rd_req_in;
  logic [31:0] req_addr_in, req_wdata_in;
  logic [3:0]  req_mask_in;
  logic        ahb_ready_in, ahb_resp_in;
  logic [31:0] ahb_rdata_in;
  logic [31:0] ahb_haddr_out, ahb_hwdata_out, rdata_out;
  logic        ahb_hwrite_out, stall_out, rdata_valid_out, bus_err_out;
  logic [1:0]  ahb_htrans_out;
  logic [3:0]  ahb_mask_out;

  msrv32_dmem_bus_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .mem_wr_req_in        (mem_wr_req_in),
    .mem_rd_req_in        (mem_rd_req_in),
    .req_addr_in          (req_addr_in),
    .req_wdata_in         (req_wdata_in),
    .req_mask_in          (req_mask_in),
    .ahb_ready_in         (ahb_ready_in),
    .ahb_resp_in          (ahb_resp_in),
    .ahb_rdata_in         (ahb_rdata_in),
    .ahb_haddr_out        (ahb_haddr_out),
    .ahb_hwdata_out       (ahb_hwdata_out),
    .ahb_hwrite_out       (ahb_hwrite_out),
    .ahb_htrans_out       (ahb_htrans_out),
    .ahb_mask_out         (ahb_mask_out),
    .stall_out            (stall_out),
    .rdata_out            (rdata_out),
    .rdata_valid_out      (rdata_valid_out),
    .bus_err_out          (bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } addr_item_t;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
  } resp_item_t;

  localparam logic [1:0] CODE_RD  = 2'b01;
  localparam logic [1:0] CODE_ERR = 2'b10;

  addr_item_t addr_sb[$];
  resp_item_t resp_sb[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          sl_waits = 0, sl_addr_wait = 0, sl_cnt = 0;
  logic        sl_err = 1'b0, sl_armed = 1'b0;
  logic [31:0] sl_rdata = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      sl_armed = 1'b0; ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    end else if (bus_err_out) begin
      sl_armed = 1'b0; ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    end else if (sl_armed) begin
      if (sl_cnt > 0) begin
        ahb_ready_in = 1'b0; ahb_resp_in = 1'b0; ahb_rdata_in = ~sl_rdata; sl_cnt--;
      end else begin
        ahb_ready_in = 1'b1; ahb_resp_in = sl_err; ahb_rdata_in = sl_rdata; sl_armed = 1'b0;
      end
    end else if (ahb_htrans_out == 2'b10) begin
      ahb_resp_in = 1'b0;
      if (sl_addr_wait > 0) begin
        ahb_ready_in = 1'b0; sl_addr_wait--;
      end else begin
        ahb_ready_in = 1'b1; sl_armed = 1'b1; sl_cnt = sl_waits;
      end
    end else begin
      ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    end
  end

  logic        mon_dp = 1'b0, mon_wr = 1'b0;
  logic [31:0] mon_wdata = '0;
  logic [3:0]  mon_mask = '0;
  addr_item_t  mon_ai;
  resp_item_t  mon_ri;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_dp = 1'b0;
    end else begin
      if (bus_err_out || rdata_valid_out) begin
        mon_dp = 1'b0;
        if (resp_sb.size() == 0) begin
          check_eq("resp_unexpected", {30'b0, bus_err_out, rdata_valid_out}, 32'h0);
        end else begin
          mon_ri = resp_sb.pop_front();
          check_eq("resp_kind", {30'b0, bus_err_out, rdata_valid_out}, {30'b0, mon_ri.code});
          if (mon_ri.code == CODE_RD) check_eq("rdata", rdata_out, mon_ri.data);
        end
      end
      if (mon_dp) begin
        if (mon_wr) begin
          check_eq("hwdata", ahb_hwdata_out, mon_wdata);
          check_eq("hmask", 32'(ahb_mask_out), 32'(mon_mask));
        end
        if (ahb_ready_in || ahb_resp_in) mon_dp = 1'b0;
      end
      if (ahb_htrans_out == 2'b10 && ahb_ready_in) begin
        if (addr_sb.size() == 0) begin
          check_eq("addr_unexpected", 32'(ahb_htrans_out), 32'h0);
        end else begin
          mon_ai = addr_sb.pop_front();
          check_eq("haddr", ahb_haddr_out, mon_ai.addr);
          check_eq("hwrite", 32'(ahb_hwrite_out), 32'(mon_ai.wr));
          mon_dp = 1'b1; mon_wr = mon_ai.wr; mon_wdata = mon_ai.wdata; mon_mask = mon_ai.mask;
        end
      end
    end
  end

  task automatic run_req(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] rdata, input int waits, input int addr_waits,
                         input logic err, input int exp_stall);
    int n = 0;
    sl_waits = waits; sl_addr_wait = addr_waits; sl_err = err; sl_rdata = rdata;
    if (wr) addr_sb.push_back('{addr & 32'hFFFF_FFFC, 1'b1, wdata, mask});
    if (rd && !(wr && err)) addr_sb.push_back('{addr & 32'hFFFF_FFFC, 1'b0, wdata, 4'h0});
    if (err) resp_sb.push_back('{CODE_ERR, 32'h0});
    else if (rd) resp_sb.push_back('{CODE_RD, rdata});
    @(posedge clk); #1;
    mem_wr_req_in = wr; mem_rd_req_in = rd;
    req_addr_in = addr; req_wdata_in = wdata; req_mask_in = mask;
    @(negedge clk);
    while (stall_out && n < 200) begin
      n++;
      @(posedge clk); #1;
      mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b0;
      @(negedge clk);
    end
    check_eq("stall_cycles", 32'(n), 32'(exp_stall));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_htrans"}, 32'(ahb_htrans_out), 32'h0);
    check_eq({tag, "_haddr"}, ahb_haddr_out, 32'h0);
    check_eq({tag, "_hwdata"}, ahb_hwdata_out, 32'h0);
    check_eq({tag, "_hwrite"}, 32'(ahb_hwrite_out), 32'h0);
    check_eq({tag, "_mask"}, 32'(ahb_mask_out), 32'h0);
    check_eq({tag, "_stall"}, 32'(stall_out), 32'h0);
    check_eq({tag, "_rdata"}, rdata_out, 32'h0);
    check_eq({tag, "_rvalid"}, 32'(rdata_valid_out), 32'h0);
    check_eq({tag, "_err"}, 32'(bus_err_out), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_wr_req_in = 1'b0; mem_rd_req_in = 1'b0;
    req_addr_in = '0; req_wdata_in = '0; req_mask_in = '0;
    ahb_ready_in = 1'b1; ahb_resp_in = 1'b0; ahb_rdata_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    run_req(1'b1, 1'b0, 32'h0000_1004, 32'h0000_AB00, 4'b0010, 32'h0, 0, 0, 1'b0, 3);
    run_req(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0, 32'hDEAD_BEEF, 3, 0, 1'b0, 6);
    run_req(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'b1111, 32'hCAFE_F00D, 0, 0, 1'b0, 5);
    run_req(1'b0, 1'b1, 32'h0000_0055, 32'h0, 4'h0, 32'h1357_2468, 0, 2, 1'b0, 5);
    run_req(1'b1, 1'b0, 32'h0000_0080, 32'hA5A5_5A5A, 4'b1100, 32'h0, 2, 0, 1'b1, 6);
    check_eq("rdata_hold", rdata_out, 32'h1357_2468);
    run_req(1'b0, 1'b1, 32'h0000_0090, 32'h0, 4'h0, 32'h0, 1000, 0, 1'b1, 19);
    check_eq("rdata_hold_timeout", rdata_out, 32'h1357_2468);

    sl_waits = 1000; sl_addr_wait = 0; sl_err = 1'b0;
    addr_sb.push_back('{32'h0000_0040, 1'b0, 32'h0, 4'h0});
    @(posedge clk); #1 mem_rd_req_in = 1'b1; req_addr_in = 32'h0000_0040;
    @(posedge clk); #1 mem_rd_req_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    sl_waits = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_req(1'b0, 1'b1, 32'h0000_0044, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 0, 1'b0, 3);

    repeat (3) @(posedge clk);
    check_eq("addr_sb_left", 32'(addr_sb.size()), 32'h0);
    check_eq("resp_sb_left", 32'(resp_sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
